xadc_drp_sequencer: RTL and testbench
=====================================

// Module: xadc_drp_sequencer
// PURPOSE
//  Sequences DRP status-register reads from the XADC for a fixed channel list, one sweep per
//  end-of-conversion trigger. Each 16-bit result is reduced to 12 bits and held per channel.
//  Sits between the XADC primitive and the fuzzy controller datapath.
//  Replaces ad-hoc alternating reads with a scheduled, timeout-protected sweep.
// PARAMETERS
//  NUM_CH   4   number of channels swept; addresses come from adc_pkg::CH_ADDR[0..NUM_CH-1]
//  TIMEOUT  15  cycles to wait for drdy after a read strobe before the read is abandoned (>=2)
// PORTS
//  clk          in   1           system clock; all logic on posedge
//  rst_n        in   1           asynchronous, active-low reset
//  enable       in   1           1 = start sweeps on trigger; 0 = in-flight sweep completes, no new sweep
//  eoc          in   1           XADC end-of-conversion; 1-cycle pulse, triggers a sweep
//  clr_err      in   1           clears the sticky timeout_err and overrun flags
//  den          out  1           DRP read strobe, exactly 1 cycle per read
//  daddr        out  7           DRP address, held from den until drdy or timeout
//  drdy         in   1           DRP data valid
//  do_data      in   16          DRP read data; the result is do_data[15:4]
//  samples      out  12*NUM_CH   channel k at [12k+11:12k]
//  sweep_done   out  1           1-cycle pulse after the last channel of a sweep is stored
//  timeout_err  out  1           sticky; a read reached TIMEOUT without drdy
//  overrun      out  1           sticky; a trigger was lost (a second eoc arrived while one was pending)
// BEHAVIOUR
//  Reset
//   - Outputs: den=0, daddr=7'h00, samples=0, sweep_done=0, timeout_err=0, overrun=0.
//   - Internal: state=IDLE, ch=0, pending=0, timeout counter=0.
//   - Asserting rst_n mid-sweep abandons the sweep at once; no partial sweep_done is produced.
//  States
//   - IDLE:  (eoc|pending)&enable -> ISSUE with ch=0, pending cleared.
//   - ISSUE: den=1, daddr=CH_ADDR[ch], counter cleared -> WAIT.
//   - WAIT:  drdy -> samples[ch]<=do_data[15:4].
//            If counter==TIMEOUT-1 with no drdy, timeout_err<=1 and samples[ch] is kept.
//            Either exit: ch==NUM_CH-1 -> DONE; else ch+1 -> ISSUE.
//   - DONE:  sweep_done=1 -> IDLE. pending&enable takes effect next cycle, via IDLE.
//  Latency
//   - eoc at cycle t -> den at t+1.
//   - drdy at cycle u -> samples valid at u+1; next den at u+2.
//  Trigger and DRP rules
//   - eoc outside IDLE sets pending. eoc while pending=1 sets overrun; pending stays 1.
//   - drdy outside WAIT is ignored. drdy in the same cycle as den cannot occur (DRP rule).
//   - den is never re-asserted before the prior read ends, so there is at most one outstanding read.
//   - drdy arriving on the timeout cycle counts as a valid read; no error is flagged.
//  Sticky flags
//   - clr_err clears timeout_err and overrun.
//   - A set event in the same cycle as clr_err wins: the flag ends at 1.
//  Enable
//   - enable=0 during a sweep: the sweep completes and pending is retained.
//   - eoc with enable=0 in IDLE is dropped and does not set pending.
//  Width rules
//   - Unsigned truncation, no rounding.
//   - ch is $clog2(NUM_CH) bits (minimum 1). The timeout counter is $clog2(TIMEOUT+1) bits.
// STRUCTURE
//  - adc_pkg holds:
//     - CH_ADDR table: 7'h13, 7'h1B, 7'h10, 7'h18 (VAUX3, VAUX11, VAUX0, VAUX8).
//     - State encoding: IDLE, ISSUE, WAIT, DONE.
//     - DRP_DATA_W=16, SAMPLE_W=12.
//  - Sub-module drp_read_port, which owns:
//     - the single-read handshake: den pulse, daddr hold, timeout counter;
//     - the result: done/timed_out pulse plus 12-bit data.
//  - The sequencer FSM owns the channel index, pending/overrun, the samples register file and sweep_done.
// TESTING
//  1. Reset, then one eoc; drdy 3 cycles after each den with do_data=16'hABC5.
//     -> daddr 13,1B,10,18 in order; every sample reads 12'hABC; one sweep_done; no flags set.
//  2. drdy withheld on ch1.
//     -> timeout_err=1 exactly TIMEOUT cycles after that den; samples[1] unchanged; ch2 read follows.
//     -> sweep_done still asserted.
//  3. eoc mid-sweep, then a second eoc mid-sweep.
//     -> overrun=1; exactly one extra sweep starts one cycle after DONE.
//  4. rst_n pulsed low while in WAIT for ch2.
//     -> all outputs return to reset values asynchronously; no sweep_done.
//     -> the next eoc restarts from ch0.
//  5. clr_err in the same cycle as a timeout.
//     -> timeout_err stays 1; clr_err one cycle later -> timeout_err reads 0.
//  6. enable=0 with an eoc in IDLE -> no den.
//     enable drops mid-sweep -> the sweep completes and no further sweep starts.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants for the XADC DRP sequencer: channel address table, FSM
// encoding and DRP/sample widths.
package adc_pkg;

  localparam int DRP_DATA_W = 16;
  localparam int DRP_ADDR_W = 7;
  localparam int SAMPLE_W   = 12;
  localparam int MAX_CH     = 4;

  // VAUX3, VAUX11, VAUX0, VAUX8 status registers
  localparam logic [DRP_ADDR_W-1:0] CH_ADDR [MAX_CH] = '{7'h13, 7'h1B, 7'h10, 7'h18};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Keep the top SAMPLE_W bits of a DRP word; unsigned truncation, no rounding.
  function automatic logic [SAMPLE_W-1:0] to_sample(input logic [DRP_DATA_W-1:0] raw);
    return SAMPLE_W'(raw >> (DRP_DATA_W - SAMPLE_W));
  endfunction

endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// DRP read bus between the sequencer (master) and the XADC primitive (slave).
interface xadc_drp_if;
  import adc_pkg::*;

  logic                  den;
  logic [DRP_ADDR_W-1:0] daddr;
  logic                  drdy;
  logic [DRP_DATA_W-1:0] do_data;

  modport master (output den, daddr, input drdy, do_data);
  modport slave  (input den, daddr, output drdy, do_data);

endinterface

// File: rtl/xadc_drp_sequencer_drp_read_port.sv
// Single DRP read: one-cycle den strobe, daddr held, timeout counter, and a
// one-cycle done/timed_out result with the reduced 12-bit data.
module drp_read_port
  import adc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DRP_ADDR_W-1:0] addr,
  xadc_drp_if.master            drp,
  output logic                  done,
  output logic                  timed_out,
  output logic [SAMPLE_W-1:0]   data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic             busy;
  logic             waiting;
  logic [CNT_W-1:0] cnt;

  // drdy is never valid in the strobe cycle, so waiting starts the cycle after den.
  assign waiting   = busy & ~drp.den;
  assign done      = waiting & drp.drdy;
  assign timed_out = waiting & ~drp.drdy & (cnt == CNT_W'(TIMEOUT - 1));
  assign data      = to_sample(drp.do_data);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drp.den   <= 1'b0;
      drp.daddr <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      drp.den <= start;
      if (start) begin
        drp.daddr <= addr;
        busy      <= 1'b1;
        cnt       <= '0;
      end else if (done || timed_out) begin
        busy <= 1'b0;
      end else if (waiting) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Sweeps the XADC channel list over DRP once per end-of-conversion trigger
// and holds the latest 12-bit result for each channel.
module xadc_drp_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       eoc,
  input  logic                       clr_err,
  xadc_drp_if.master                 drp,
  output logic [SAMPLE_W*NUM_CH-1:0] samples,
  output logic                       sweep_done,
  output logic                       timeout_err,
  output logic                       overrun
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [1:0]            state;
  logic [CH_W-1:0]       ch;
  logic                  pending;
  logic                  go;
  logic                  start;
  logic                  rd_end;
  logic                  rd_done;
  logic                  rd_timeout;
  logic [SAMPLE_W-1:0]   rd_data;
  logic [DRP_ADDR_W-1:0] start_addr;

  assign go         = (state == IDLE) & (eoc | pending) & enable;
  assign start      = go | (state == ISSUE);
  assign start_addr = go ? CH_ADDR[0] : CH_ADDR[ch];
  assign rd_end     = (state == WAIT) & (rd_done | rd_timeout);
  assign sweep_done = (state == DONE);

  drp_read_port #(.TIMEOUT(TIMEOUT)) u_read_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr      (start_addr),
    .drp       (drp),
    .done      (rd_done),
    .timed_out (rd_timeout),
    .data      (rd_data)
  );

  // NOTE: the samples register file is reset explicitly because consumers
  // read it before the first sweep completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      pending     <= 1'b0;
      samples     <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // A set event in the same cycle as clr_err leaves the flag at 1.
      overrun     <= (eoc & pending) | (overrun & ~clr_err);
      timeout_err <= (rd_end & rd_timeout) | (timeout_err & ~clr_err);

      if (go)
        pending <= 1'b0;
      else if (eoc && state != IDLE)
        pending <= 1'b1;

      // Leaving IDLE launches the ch0 strobe on the same edge, so eoc->den is
      // one cycle; ISSUE spaces the strobes between channels.
      case (state)
        IDLE: begin
          if (go) begin
            ch    <= '0;
            state <= WAIT;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (rd_end) begin
            if (rd_done)
              samples[SAMPLE_W*ch +: SAMPLE_W] <= rd_data;
            if (ch == LAST_CH) begin
              state <= DONE;
            end else begin
              ch    <= ch + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench: table-driven sweeps, hand-written corner sequences and
// randomized DRP latency checked against a transaction-level channel model.
module tb_xadc_drp_sequencer;
  import adc_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 15;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic enable  = 1'b0;
  logic eoc     = 1'b0;
  logic clr_err = 1'b0;
  logic [SAMPLE_W*NUM_CH-1:0] samples;
  logic sweep_done, timeout_err, overrun;

  xadc_drp_if bus();

  xadc_drp_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .eoc         (eoc),
    .clr_err     (clr_err),
    .drp         (bus),
    .samples     (samples),
    .sweep_done  (sweep_done),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int addr_index(input logic [6:0] a);
    for (int i = 0; i < NUM_CH; i++)
      if (CH_ADDR[i] == a) return i;
    return 0;
  endfunction

  // DRP slave model: per-channel latency/data, or random; 0 latency = no reply.
  int          rsp_delay [NUM_CH];
  logic [15:0] rsp_data  [NUM_CH];
  bit          rsp_random = 1'b0;
  logic [6:0]  log_addr [$];
  bit          log_ok   [$];
  logic [15:0] log_data [$];
  int          log_cyc  [$];
  int          rcnt = 0;
  logic [15:0] rdata;
  logic [6:0]  raddr;
  logic        den_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rcnt     = 0;
      bus.drdy = 1'b0;
      den_prev = 1'b0;
    end else begin
      bus.drdy    = 1'b0;
      bus.do_data = 16'($urandom);
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.drdy    = 1'b1;
          bus.do_data = rdata;
          check("daddr held until drdy", bus.daddr, raddr);
        end
      end
      if (bus.den) begin
        int k;
        int d;
        check("den single cycle", den_prev, 0);
        k = addr_index(bus.daddr);
        if (rsp_random) begin
          d     = $urandom_range(TIMEOUT + 3, 1);
          rdata = 16'($urandom);
        end else begin
          d     = rsp_delay[k];
          rdata = rsp_data[k];
        end
        if (d < 1 || d > TIMEOUT) d = 0;
        raddr = bus.daddr;
        rcnt  = d;
        log_addr.push_back(bus.daddr);
        log_ok.push_back(d != 0);
        log_data.push_back(rdata);
        log_cyc.push_back(cyc);
      end
      den_prev = bus.den;
      if (sweep_done) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1;
    step();
    eoc = 1'b0;
  endtask

  task automatic wait_sweep(input string name, input int budget);
    int n = 1;
    step();
    while (!sweep_done && n < budget) begin
      step();
      n++;
    end
    check(name, sweep_done, 1'b1);
  endtask

  task automatic wait_log(input int target, input int budget);
    int n = 0;
    while (log_addr.size() < target && n < budget) begin
      step();
      n++;
    end
    check("den issued within budget", log_addr.size() >= target, 1'b1);
  endtask

  task automatic set_all(input int delay, input logic [15:0] data);
    for (int k = 0; k < NUM_CH; k++) begin
      rsp_delay[k] = delay;
      rsp_data[k]  = data;
    end
  endtask

  typedef struct {
    logic [63:0] data;
    int          delay;
    logic [47:0] exp_samples;
    logic        exp_err;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int base, dc, t, d1;
    logic [SAMPLE_W-1:0] exp_s [NUM_CH];
    logic [47:0] exp_pk;
    logic exp_err;

    vecs[0] = '{64'hABC5_ABC5_ABC5_ABC5, 3,       48'hABC_ABC_ABC_ABC, 1'b0};
    vecs[1] = '{64'h8010_000F_FFFF_0000, 1,       48'h801_000_FFF_000, 1'b0};
    vecs[2] = '{64'hDEF0_9ABC_5678_1234, TIMEOUT, 48'hDEF_9AB_567_123, 1'b0};

    set_all(3, 16'hABC5);
    step();
    step();
    check("reset den", bus.den, 0);
    check("reset daddr", bus.daddr, 0);
    check("reset samples", samples, 0);
    check("reset sweep_done", sweep_done, 0);
    check("reset timeout_err", timeout_err, 0);
    check("reset overrun", overrun, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    step();

    // Table-driven full sweeps
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rsp_delay[k] = vecs[v].delay;
        rsp_data[k]  = vecs[v].data[16*k +: 16];
      end
      base = log_addr.size();
      dc   = done_cnt;
      t    = cyc;
      pulse_eoc();
      wait_sweep("vec sweep_done", 150);
      repeat (3) step();
      check("vec samples", samples, vecs[v].exp_samples);
      check("vec timeout_err", timeout_err, vecs[v].exp_err);
      check("vec one sweep_done", done_cnt - dc, 1);
      check("vec read count", log_addr.size() - base, NUM_CH);
      if (log_addr.size() >= base + NUM_CH) begin
        check("vec eoc->den latency", log_cyc[base] - t, 1);
        check("vec drdy->den latency", log_cyc[base+1] - log_cyc[base], vecs[v].delay + 2);
        for (int i = 0; i < NUM_CH; i++)
          check("vec daddr order", log_addr[base+i], CH_ADDR[i]);
      end
    end

    // Timeout on ch1, with clr_err in the timeout cycle
    set_all(2, 16'h4444);
    rsp_delay[1] = 0;
    base = log_addr.size();
    pulse_eoc();
    wait_log(base + 2, 40);
    if (log_cyc.size() > base + 1) begin
      d1 = log_cyc[base+1];
      while (cyc < d1 + TIMEOUT) step();
      check("timeout_err before timeout", timeout_err, 0);
      clr_err = 1'b1;
      step();
      check("timeout_err set wins over clr_err", timeout_err, 1);
      step();
      clr_err = 1'b0;
      check("timeout_err cleared", timeout_err, 0);
      wait_sweep("timeout sweep_done", 80);
      check("timeout samples[1] kept", samples, 48'h444_444_567_444);
      if (log_addr.size() > base + 2) begin
        check("ch2 after timeout addr", log_addr[base+2], 7'h10);
        check("ch2 after timeout den cycle", log_cyc[base+2] - d1, TIMEOUT + 2);
      end
    end

    // Pending then overrun during a sweep
    repeat (3) step();
    set_all(3, 16'h1110);
    base = log_addr.size();
    dc   = done_cnt;
    pulse_eoc();
    repeat (4) step();
    pulse_eoc();
    check("no overrun on first pending", overrun, 0);
    repeat (3) step();
    pulse_eoc();
    check("overrun set", overrun, 1);
    wait_sweep("overrun first sweep_done", 80);
    step();
    check("no den right after DONE", bus.den, 0);
    step();
    check("pending sweep den", bus.den, 1);
    wait_sweep("overrun second sweep_done", 80);
    repeat (30) step();
    check("exactly one extra sweep", done_cnt - dc, 2);
    check("extra sweep reads", log_addr.size() - base, 2 * NUM_CH);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("overrun cleared", overrun, 0);

    // Async reset while waiting on ch2
    set_all(3, 16'h7770);
    rsp_delay[2] = 0;
    base = log_addr.size();
    pulse_eoc();
    wait_log(base + 3, 40);
    repeat (3) step();
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check("async reset den", bus.den, 0);
    check("async reset daddr", bus.daddr, 0);
    check("async reset samples", samples, 0);
    check("async reset sweep_done", sweep_done, 0);
    check("async reset flags", {timeout_err, overrun}, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (25) step();
    check("no sweep_done after reset", done_cnt - dc, 0);
    check("no timeout after reset", timeout_err, 0);
    set_all(2, 16'h2220);
    base = log_addr.size();
    pulse_eoc();
    wait_sweep("post-reset sweep_done", 80);
    if (log_addr.size() > base) check("post-reset restarts at ch0", log_addr[base], 7'h13);
    step();
    check("post-reset samples", samples, 48'h222_222_222_222);

    // Enable handling
    enable = 1'b0;
    base = log_addr.size();
    pulse_eoc();
    repeat (20) step();
    check("disabled eoc in IDLE dropped", log_addr.size() - base, 0);
    enable = 1'b1;
    pulse_eoc();
    wait_log(base + 1, 10);
    enable = 1'b0;
    step();
    pulse_eoc();
    wait_sweep("disabled sweep completes", 80);
    repeat (20) step();
    check("no sweep while disabled", log_addr.size() - base, NUM_CH);
    enable = 1'b1;
    repeat (3) step();
    check("retained pending starts", log_addr.size() - base, NUM_CH + 1);
    wait_sweep("retained pending sweep_done", 80);
    repeat (2) step();

    // Randomized DRP latency/data against the channel model
    for (int k = 0; k < NUM_CH; k++) exp_s[k] = 12'h222;
    exp_err    = 1'b0;
    rsp_random = 1'b1;
    for (int s = 0; s < 40; s++) begin
      repeat ($urandom_range(4, 0)) step();
      base = log_addr.size();
      pulse_eoc();
      wait_sweep("random sweep_done", 200);
      step();
      for (int i = 0; i < NUM_CH; i++) begin
        if (log_addr.size() > base + i) begin
          check("random daddr order", log_addr[base+i], CH_ADDR[i]);
          if (log_ok[base+i]) exp_s[i] = log_data[base+i][15:4];
          else                exp_err  = 1'b1;
        end
      end
      for (int k = 0; k < NUM_CH; k++) exp_pk[12*k +: 12] = exp_s[k];
      check("random samples", samples, exp_pk);
      check("random timeout_err", timeout_err, exp_err);
    end
    rsp_random = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
